approx_mult_err_monitor: RTL and testbench
==========================================

Name: approx_mult_err_monitor

Overview:
Hardware error-metric collector that sits directly downstream of the approximate 4x4 multiplier. It consumes operand pairs and the approximate product, recomputes the exact product internally, and accumulates the following over a fixed-length sweep:
- mismatch count
- sum of absolute error
- sum of squared error
- max absolute error
- sum of percentage relative error
This replaces post-processing in simulation and allows on-chip characterisation of multiplier variants.

Parameters:
W, 4, operand width; product width is 2W.
N_SAMPLES, 256, samples accepted per sweep; must be >= 1.
ACC_W, 32, width of every accumulator output.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE
in_valid  input  1  sample valid
in_ready  output  1  monitor can accept a sample this cycle
a  input  W  operand A
b  input  W  operand B
p_approx  input  2W  approximate product for (a, b)
busy  output  1  high in COLLECT or DIV
done  output  1  high in DONE; results stable
sample_cnt  output  ACC_W  samples accepted this sweep
err_count  output  ACC_W  samples with p_approx != a*b
sum_abs_err  output  ACC_W  sum of |p_approx - a*b|
sum_sq_err  output  ACC_W  sum of (p_approx - a*b)^2
max_abs_err  output  2W  largest |p_approx - a*b| this sweep
sum_rel_err  output  ACC_W  sum of floor(|diff|*100 / exact), only over samples with exact != 0

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - State = IDLE.
  - in_ready, busy, done = 0.
  - All counters and accumulators = 0.
  - A reset in any state, including mid-DIV, aborts the sweep with no partial update.
- States: IDLE, COLLECT, DIV, DONE.
- IDLE:
  - in_ready = 0; in_valid is ignored.
  - start -> clear all accumulators and sample_cnt, go to COLLECT next cycle.
- COLLECT:
  - in_ready = 1 (combinational from state).
  - Accept occurs on in_valid && in_ready at the clock edge.
  - Per accept:
    - exact = a*b (2W bits).
    - diff = |p_approx - exact| (2W bits, unsigned).
    - sample_cnt += 1.
    - sum_abs_err += diff.
    - sum_sq_err += diff*diff.
    - max_abs_err = max(max_abs_err, diff).
    - err_count += (diff != 0).
  - All of these update at the accept edge and are visible the following cycle.
  - If diff != 0 and exact != 0: latch dividend = diff*100 and divisor = exact, then go to DIV.
  - Otherwise: if this was sample N_SAMPLES go to DONE, else stay in COLLECT (back-to-back accepts allowed).
  - start is ignored.
- DIV:
  - in_ready = 0.
  - Restoring divider, one quotient bit per cycle, Q_BITS = 2W+7 cycles (15 for W=4).
  - On completion, sum_rel_err += quotient (truncating division).
  - Next state is DONE if sample_cnt == N_SAMPLES, else COLLECT.
  - For a mismatched sample, the next accept is therefore possible no earlier than Q_BITS+1 cycles after the accepting edge.
  - start is ignored.
- DONE:
  - done = 1; in_ready = 0; all outputs held.
  - start clears everything and returns to COLLECT. done drops the cycle after start.
- Arithmetic:
  - All accumulators saturate at 2^ACC_W - 1 and do not wrap.
  - sample_cnt stops at N_SAMPLES.
  - Samples with exact == 0 contribute to every metric except sum_rel_err.
- The mean relative error (sum_rel_err / N_SAMPLES) is computed by the consumer, not by this block.

Test Plan:
1. Exact model (p_approx = a*b), full 256 sweep with in_valid held high:
   - done asserts after exactly 256 accepts, 256 consecutive cycles with no DIV stall.
   - err_count, sum_abs_err, sum_sq_err, max_abs_err, sum_rel_err all = 0; sample_cnt = 256.
2. N_SAMPLES=1, single sample a=3, b=5, p_approx=14:
   - in_ready low for 15 cycles after the accept.
   - Results: err_count=1, sum_abs_err=1, sum_sq_err=1, max_abs_err=1, sum_rel_err=6 (100/15 truncated).
3. N_SAMPLES=3, samples (0,7,p=2), (2,2,p=11), (4,4,p=14):
   - First sample is a zero-exact case: no DIV stall.
   - Results: sum_abs_err=11, sum_sq_err=4+49+4=57, max_abs_err=7, err_count=3.
   - sum_rel_err = 175 + 12 = 187.
4. Reset mid-DIV (rst on 5th DIV cycle):
   - Next cycle: IDLE, all outputs 0.
   - in_valid is ignored until start.
5. start pulsed during COLLECT and again in DONE:
   - The COLLECT pulse is ignored.
   - The DONE pulse clears all accumulators and re-enters COLLECT; done drops the next cycle.
6. Saturation with ACC_W=8, N_SAMPLES=4, each sample a=15, b=15, p_approx=0 (diff=225):
   - sum_abs_err saturates at 255 and sum_sq_err saturates at 255.
   - max_abs_err=225, err_count=4.

Source files
------------

// File: rtl/approx_mult_err_monitor.sv
// Error-metric collector for an approximate WxW multiplier.
// Recomputes the exact product for each accepted sample and accumulates
// mismatch count, absolute/squared error sums, max error, and the sum of
// truncated percentage relative error. The percentage uses a bit-serial
// restoring divider that stalls intake while it runs.
module approx_mult_err_monitor #(
  parameter int W         = 4,
  parameter int N_SAMPLES = 256,
  parameter int ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   p_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sample_cnt,
  output logic [ACC_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [ACC_W-1:0] sum_sq_err,
  output logic [2*W-1:0]   max_abs_err,
  output logic [ACC_W-1:0] sum_rel_err
);

  localparam int PW = 2*W;          // product / diff width
  localparam int QB = PW + 7;       // diff*100 fits in PW+7 bits (100 < 128)
  localparam int CW = $clog2(QB);   // divider step counter width
  // Working width for saturating adds: wide enough for any addend plus carry.
  localparam int SW = ((ACC_W > 2*PW) ? ACC_W : 2*PW) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DIV, DONE} state_t;

  state_t            state_q;
  logic [ACC_W-1:0]  cnt_q, err_q, abs_q, sq_q, rel_q;
  logic [PW-1:0]     max_q;
  logic [QB-1:0]     dvd_q;         // dividend, shifted out MSB first
  logic [PW-1:0]     dvs_q;         // divisor (exact product)
  logic [PW-1:0]     rem_q;
  logic [QB-2:0]     quo_q;         // quotient bits gathered so far
  logic [CW-1:0]     step_q;

  logic [PW-1:0]     exact, diff;
  logic [2*PW-1:0]   sq;
  logic              accept, last;
  logic [ACC_W-1:0]  cnt_d;
  logic [PW:0]       trial;
  logic              ge;
  logic [PW-1:0]     rem_d;
  logic [QB-1:0]     quo_d;

  // Saturating accumulate: clamp at all-ones instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [SW-1:0] x);
    logic [SW:0] s;
    s = (SW+1)'(acc) + (SW+1)'(x);
    if (s > (SW+1)'({ACC_W{1'b1}})) return '1;
    return s[ACC_W-1:0];
  endfunction

  // Per-sample error terms and one restoring-divider step.
  always_comb begin
    exact  = PW'(a) * PW'(b);
    diff   = (p_approx >= exact) ? (p_approx - exact) : (exact - p_approx);
    sq     = (2*PW)'(diff) * (2*PW)'(diff);
    accept = in_valid && (state_q == COLLECT);
    cnt_d  = cnt_q + 1'b1;
    last   = (cnt_d == ACC_W'(N_SAMPLES));
    trial  = {rem_q, dvd_q[QB-1]};
    ge     = (trial >= {1'b0, dvs_q});
    rem_d  = ge ? PW'(trial - {1'b0, dvs_q}) : trial[PW-1:0];
    quo_d  = {quo_q, ge};
  end

  // Sweep FSM, accumulators and divider datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      abs_q   <= '0;
      sq_q    <= '0;
      rel_q   <= '0;
      max_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      step_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            cnt_q   <= '0;
            err_q   <= '0;
            abs_q   <= '0;
            sq_q    <= '0;
            rel_q   <= '0;
            max_q   <= '0;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            cnt_q <= cnt_d;
            err_q <= sat_add(err_q, SW'(diff != '0));
            abs_q <= sat_add(abs_q, SW'(diff));
            sq_q  <= sat_add(sq_q, SW'(sq));
            if (diff > max_q) max_q <= diff;
            // Zero-exact samples skip the divide (relative error undefined).
            if (diff != '0 && exact != '0) begin
              dvd_q   <= QB'(diff) * QB'(7'd100);
              dvs_q   <= exact;
              rem_q   <= '0;
              quo_q   <= '0;
              step_q  <= '0;
              state_q <= DIV;
            end else if (last) begin
              state_q <= DONE;
            end
          end
        end
        DIV: begin
          dvd_q  <= {dvd_q[QB-2:0], 1'b0};
          rem_q  <= rem_d;
          quo_q  <= quo_d[QB-2:0];
          step_q <= step_q + 1'b1;
          if (step_q == CW'(QB-1)) begin
            rel_q   <= sat_add(rel_q, SW'(quo_d));
            state_q <= (cnt_q == ACC_W'(N_SAMPLES)) ? DONE : COLLECT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == COLLECT);
  assign busy        = (state_q == COLLECT) || (state_q == DIV);
  assign done        = (state_q == DONE);
  assign sample_cnt  = cnt_q;
  assign err_count   = err_q;
  assign sum_abs_err = abs_q;
  assign sum_sq_err  = sq_q;
  assign max_abs_err = max_q;
  assign sum_rel_err = rel_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor. Four instances share the
// stimulus; each scenario checks the instance whose parameters it targets.
module tb_approx_mult_err_monitor;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [3:0] a, b;
  logic [7:0] p;

  // d0: N=256, d1: N=1, d2: N=3, d3: N=4 with 8-bit accumulators
  logic        rdy0, busy0, done0, rdy1, busy1, done1;
  logic        rdy2, busy2, done2, rdy3, busy3, done3;
  logic [31:0] cnt0, err0, abs0, sq0, rel0;
  logic [31:0] cnt1, err1, abs1, sq1, rel1;
  logic [31:0] cnt2, err2, abs2, sq2, rel2;
  logic [7:0]  cnt3, err3, abs3, sq3, rel3;
  logic [7:0]  max0, max1, max2, max3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_mult_err_monitor #(.W(4), .N_SAMPLES(256), .ACC_W(32)) d0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .p_approx(p), .busy(busy0), .done(done0), .sample_cnt(cnt0),
    .err_count(err0), .sum_abs_err(abs0), .sum_sq_err(sq0), .max_abs_err(max0),
    .sum_rel_err(rel0));
  approx_mult_err_monitor #(.W(4), .N_SAMPLES(1), .ACC_W(32)) d1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .p_approx(p), .busy(busy1), .done(done1), .sample_cnt(cnt1),
    .err_count(err1), .sum_abs_err(abs1), .sum_sq_err(sq1), .max_abs_err(max1),
    .sum_rel_err(rel1));
  approx_mult_err_monitor #(.W(4), .N_SAMPLES(3), .ACC_W(32)) d2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .p_approx(p), .busy(busy2), .done(done2), .sample_cnt(cnt2),
    .err_count(err2), .sum_abs_err(abs2), .sum_sq_err(sq2), .max_abs_err(max2),
    .sum_rel_err(rel2));
  approx_mult_err_monitor #(.W(4), .N_SAMPLES(4), .ACC_W(8)) d3 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy3),
    .a(a), .b(b), .p_approx(p), .busy(busy3), .done(done3), .sample_cnt(cnt3),
    .err_count(err3), .sum_abs_err(abs3), .sum_sq_err(sq3), .max_abs_err(max3),
    .sum_rel_err(rel3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] tp);
    a = ta; b = tb; p = tp; in_valid = 1'b1;
  endtask

  initial begin
    int stall, early, n, nb;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; p = '0;
    tick(); tick();
    chk("rst_rdy", rdy0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_err", err0, 0);
    rst = 1'b0;

    // 1: exact products over the full 16x16 space, no stalls
    pulse_start();
    chk("t1_rdy", rdy0, 1);
    stall = 0; early = 0;
    for (int i = 0; i < 256; i++) begin
      drive(4'(i >> 4), 4'(i), 8'({4'b0, 4'(i >> 4)} * {4'b0, 4'(i)}));
      if (!rdy0) stall++;
      if (done0) early++;
      tick();
    end
    in_valid = 1'b0;
    chk("t1_stall", stall, 0);
    chk("t1_early", early, 0);
    chk("t1_done", done0, 1);
    chk("t1_cnt", cnt0, 256);
    chk("t1_err", err0, 0);
    chk("t1_abs", abs0, 0);
    chk("t1_sq", sq0, 0);
    chk("t1_max", max0, 0);
    chk("t1_rel", rel0, 0);

    // 2: single mismatched sample, 15-cycle divide
    do_reset(); pulse_start();
    drive(4'd3, 4'd5, 8'd14);
    chk("t2_rdy", rdy1, 1);
    tick(); in_valid = 1'b0;
    nb = 0;
    for (int k = 0; k < 15; k++) begin
      if (busy1 && !done1 && !rdy1) nb++;
      tick();
    end
    chk("t2_divcyc", nb, 15);
    chk("t2_done", done1, 1);
    chk("t2_err", err1, 1);
    chk("t2_abs", abs1, 1);
    chk("t2_sq", sq1, 1);
    chk("t2_max", max1, 1);
    chk("t2_rel", rel1, 6);

    // 3: zero-exact sample skips divide; two divides follow
    do_reset(); pulse_start();
    drive(4'd0, 4'd7, 8'd2); tick();
    chk("t3_nostall", rdy2, 1);
    drive(4'd2, 4'd2, 8'd11); tick(); in_valid = 1'b0;
    n = 0;
    while (!rdy2 && n < 40) begin tick(); n++; end
    chk("t3_stall", n, 15);
    drive(4'd4, 4'd4, 8'd14); tick(); in_valid = 1'b0;
    n = 0;
    while (!done2 && n < 40) begin tick(); n++; end
    chk("t3_done", done2, 1);
    chk("t3_cnt", cnt2, 3);
    chk("t3_err", err2, 3);
    chk("t3_abs", abs2, 11);
    chk("t3_sq", sq2, 57);
    chk("t3_max", max2, 7);
    chk("t3_rel", rel2, 187);

    // 4: reset on the fifth divide cycle aborts everything
    do_reset(); pulse_start();
    drive(4'd2, 4'd2, 8'd11); tick(); in_valid = 1'b0;
    repeat (4) tick();
    chk("t4_indiv", busy2 && !rdy2, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_busy", busy2, 0);
    chk("t4_cnt", cnt2, 0);
    chk("t4_abs", abs2, 0);
    chk("t4_max", max2, 0);
    chk("t4_rel", rel2, 0);
    drive(4'd3, 4'd3, 8'd1);
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t4_idle_rdy", rdy2, 0);
    chk("t4_idle_cnt", cnt2, 0);
    repeat (20) tick();
    chk("t4_idle_rel", rel2, 0);

    // 5: start ignored in COLLECT, restarts from DONE
    pulse_start();
    drive(4'd2, 4'd3, 8'd6); tick();
    drive(4'd1, 4'd1, 8'd1); start = 1'b1; tick(); start = 1'b0;
    chk("t5_cnt", cnt2, 2);
    chk("t5_busy", busy2, 1);
    drive(4'd3, 4'd3, 8'd8); tick(); in_valid = 1'b0;
    n = 0;
    while (!done2 && n < 40) begin tick(); n++; end
    chk("t5_done", done2, 1);
    chk("t5_err", err2, 1);
    chk("t5_rel", rel2, 11);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_drop", done2, 0);
    chk("t5_rdy", rdy2, 1);
    chk("t5_clr_cnt", cnt2, 0);
    chk("t5_clr_err", err2, 0);
    chk("t5_clr_rel", rel2, 0);

    // 6: 8-bit accumulators saturate
    do_reset(); pulse_start();
    for (int s = 0; s < 4; s++) begin
      drive(4'd15, 4'd15, 8'd0); tick(); in_valid = 1'b0;
      n = 0;
      while (!rdy3 && !done3 && n < 40) begin tick(); n++; end
    end
    chk("t6_done", done3, 1);
    chk("t6_cnt", cnt3, 4);
    chk("t6_err", err3, 4);
    chk("t6_abs", abs3, 255);
    chk("t6_sq", sq3, 255);
    chk("t6_max", max3, 225);
    chk("t6_rel", rel3, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
